receiver: RTL and testbench

//  UART serial receiver; counterpart of the transmitter in uart16550. Recovers 5-8 data bits,

---
 rtl/uart_pkg.sv | 26 ++
 rtl/rx_bit_sampler.sv | 71 +++++++
 rtl/receiver.sv | 139 +++++++++++++
 tb/tb_receiver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, word-length codes and data-bit helper.
package uart_pkg;

    localparam int unsigned DATA_BITS_MIN = 5;

    typedef enum logic [1:0] {
        WL_5 = 2'b00,
        WL_6 = 2'b01,
        WL_7 = 2'b10,
        WL_8 = 2'b11
    } word_len_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    function automatic logic [3:0] data_bits(input logic [1:0] wl);
        return 4'(DATA_BITS_MIN) + {2'b00, wl};
    endfunction

endpackage

// File: rtl/rx_bit_sampler.sv
// rx synchroniser, falling-edge detect, baud counter and bit-sample strobe.
// RX_MAJORITY_VOTE_EN: 3-sample majority around mid-bit, strobe one clk after the mid sample.
module rx_bit_sampler
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_baud_rate_cnt,
    input  logic        i_rx,
    input  logic        i_idle,
    output logic        o_start_edge,
    output logic        o_sample,
    output logic        o_bit,
    output logic        o_rx_s
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_d;
    logic [15:0]            r_baud_cnt;
    logic                   w_rx_s;
    logic [15:0]            w_half;

    assign w_rx_s = r_sync[SYNC_STAGES-1];
    assign w_half = i_baud_rate_cnt >> 1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_rx_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
            r_rx_d <= w_rx_s;
        end
    end

    // Held at 0 while idle so a start edge begins counting from a known phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
        end else if (i_idle || r_baud_cnt >= i_baud_rate_cnt) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic r_rx_dd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_dd <= 1'b1;
        end else begin
            r_rx_dd <= r_rx_d;
        end
    end

    // Strobe lands one clk after mid-bit, when the third vote sample is available.
    assign o_sample = !i_idle && (r_baud_cnt == w_half + 16'd1);
    assign o_bit    = (w_rx_s & r_rx_d) | (w_rx_s & r_rx_dd) | (r_rx_d & r_rx_dd);
`else
    assign o_sample = !i_idle && (r_baud_cnt == w_half);
    assign o_bit    = w_rx_s;
`endif

    assign o_start_edge = r_rx_d & ~w_rx_s;
    assign o_rx_s       = w_rx_s;

endmodule

// File: rtl/receiver.sv
// UART receiver: frame FSM and shift register; bit timing lives in rx_bit_sampler.
// RX_MAJORITY_VOTE_EN selects majority-vote sampling in the sampler.
module receiver
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  word_length,
    input  logic [15:0] baud_rate_cnt,
    input  logic        parity_en,
    input  logic        even_parity,
    input  logic        stop_bits,
    input  logic        rx,
    output logic [8:0]  po_rx_data,
    output logic        po_flag,
    output logic        parity_err,
    output logic        framing_err,
    output logic        break_int,
    output logic        rx_busy
);

    rx_state_t   r_state;
    logic [1:0]  r_wl;
    logic        r_pen;
    logic        r_even;
    logic [2:0]  r_bit_cnt;
    logic [8:0]  r_shift;
    logic [8:0]  r_data;
    logic        r_flag;
    logic        r_perr;
    logic        r_ferr;
    logic        r_brk;

    logic        w_start_edge;
    logic        w_sample;
    logic        w_bit;
    logic        w_rx_s;
    logic [2:0]  w_last;
    logic [3:0]  w_par_idx;
    logic        w_unused_ok;

    // Stop-bit count only matters to the transmitter.
    assign w_unused_ok = stop_bits;

    rx_bit_sampler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_baud_rate_cnt (baud_rate_cnt),
        .i_rx            (rx),
        .i_idle          (r_state == IDLE),
        .o_start_edge    (w_start_edge),
        .o_sample        (w_sample),
        .o_bit           (w_bit),
        .o_rx_s          (w_rx_s)
    );

    assign w_last    = 3'(data_bits(r_wl) - 4'd1);
    assign w_par_idx = data_bits(r_wl);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wl      <= '0;
            r_pen     <= 1'b0;
            r_even    <= 1'b0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_flag    <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_brk     <= 1'b0;
        end else begin
            r_flag <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        r_state   <= START;
                        r_wl      <= word_length;
                        r_pen     <= parity_en;
                        r_even    <= even_parity;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                    end
                end
                START: begin
                    if (w_sample) begin
                        r_state <= w_bit ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (w_sample) begin
                        r_shift[r_bit_cnt] <= w_bit;
                        if (r_bit_cnt == w_last) begin
                            r_state <= r_pen ? PARITY : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (w_sample) begin
                        r_shift[w_par_idx] <= w_bit;
                        r_state            <= STOP;
                    end
                end
                STOP: begin
                    if (w_sample) begin
                        // Shift register holds data and parity; bits above are zero.
                        r_flag  <= 1'b1;
                        r_data  <= r_shift;
                        r_perr  <= r_pen & ((^r_shift) ^ ~r_even);
                        r_ferr  <= ~w_bit;
                        r_brk   <= ~w_bit & (r_shift == '0);
                        r_state <= w_bit ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign po_rx_data  = r_data;
    assign po_flag     = r_flag;
    assign parity_err  = r_perr;
    assign framing_err = r_ferr;
    assign break_int   = r_brk;
    assign rx_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_receiver.sv
// Directed self-checking bench for receiver; bit period 16 clk (baud_rate_cnt=15).
module tb_receiver;

`ifdef RX_MAJORITY_VOTE_EN
    localparam int LAT = 156;
`else
    localparam int LAT = 155;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  word_length;
    logic [15:0] baud_rate_cnt;
    logic        parity_en;
    logic        even_parity;
    logic        stop_bits;
    logic        rx;
    logic [8:0]  po_rx_data;
    logic        po_flag;
    logic        parity_err;
    logic        framing_err;
    logic        break_int;
    logic        rx_busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int flag_cnt = 0;
    int flag_cyc = 0;

    receiver #(
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .word_length   (word_length),
        .baud_rate_cnt (baud_rate_cnt),
        .parity_en     (parity_en),
        .even_parity   (even_parity),
        .stop_bits     (stop_bits),
        .rx            (rx),
        .po_rx_data    (po_rx_data),
        .po_flag       (po_flag),
        .parity_err    (parity_err),
        .framing_err   (framing_err),
        .break_int     (break_int),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (po_flag === 1'b1) begin
            flag_cnt = flag_cnt + 1;
            flag_cyc = cyc;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int unsigned nd,
                              input logic has_par, input logic par, input logic stp);
        send_bit(1'b0);
        for (int unsigned i = 0; i < nd; i++) send_bit(d[i]);
        if (has_par) send_bit(par);
        send_bit(stp);
    endtask

    task automatic chk_out(input string tag, input logic [8:0] d,
                           input logic pe, input logic fe, input logic bi);
        chk({tag, "_data"}, 32'(po_rx_data), 32'(d));
        chk({tag, "_perr"}, 32'(parity_err), 32'(pe));
        chk({tag, "_ferr"}, 32'(framing_err), 32'(fe));
        chk({tag, "_brk"},  32'(break_int), 32'(bi));
    endtask

    initial begin
        int base;
        int t_start;
        logic [7:0] d;
        logic seen_busy;
        logic ended;

        rst_n         = 1'b0;
        rx            = 1'b1;
        word_length   = 2'b11;
        baud_rate_cnt = 16'd15;
        parity_en     = 1'b0;
        even_parity   = 1'b0;
        stop_bits     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        chk("rst_flag", 32'(po_flag), 32'd0);
        chk_out("rst", 9'h000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 1: 8N1 0xA5 with latency from start edge
        base    = flag_cnt;
        t_start = cyc;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        repeat (32) @(negedge clk);
        chk("t1_flags", 32'(flag_cnt - base), 32'd1);
        chk("t1_latency", 32'(flag_cyc - t_start), 32'(LAT));
        chk_out("t1", 9'h0A5, 1'b0, 1'b0, 1'b0);

        // 2: 5E1, 0x15 good parity then bad parity; word_length changed mid-frame
        word_length = 2'b00;
        parity_en   = 1'b1;
        even_parity = 1'b1;
        base = flag_cnt;
        send_frame(8'h15, 5, 1'b1, 1'b1, 1'b1);
        repeat (32) @(negedge clk);
        chk("t2a_flags", 32'(flag_cnt - base), 32'd1);
        chk_out("t2a", 9'h035, 1'b0, 1'b0, 1'b0);
        base = flag_cnt;
        d = 8'h15;
        send_bit(1'b0);
        word_length = 2'b11;
        for (int unsigned i = 0; i < 5; i++) send_bit(d[i]);
        send_bit(1'b0);
        send_bit(1'b1);
        word_length = 2'b00;
        repeat (32) @(negedge clk);
        chk("t2b_flags", 32'(flag_cnt - base), 32'd1);
        chk_out("t2b", 9'h015, 1'b1, 1'b0, 1'b0);

        // 3: framing error then a clean frame
        word_length = 2'b11;
        parity_en   = 1'b0;
        base = flag_cnt;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
        rx = 1'b1;
        repeat (32) @(negedge clk);
        chk("t3a_flags", 32'(flag_cnt - base), 32'd1);
        chk_out("t3a", 9'h03C, 1'b0, 1'b1, 1'b0);
        base = flag_cnt;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        repeat (32) @(negedge clk);
        chk("t3b_flags", 32'(flag_cnt - base), 32'd1);
        chk_out("t3b", 9'h05A, 1'b0, 1'b0, 1'b0);

        // 4: break, then re-arm only after rx high and a fresh start
        base = flag_cnt;
        rx = 1'b0;
        repeat (192) @(negedge clk);
        chk("t4_brk_flags", 32'(flag_cnt - base), 32'd1);
        chk_out("t4", 9'h000, 1'b0, 1'b1, 1'b1);
        chk("t4_busy_low", 32'(rx_busy), 32'd1);
        rx = 1'b1;
        repeat (48) @(negedge clk);
        chk("t4_no_extra", 32'(flag_cnt - base), 32'd1);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
        repeat (32) @(negedge clk);
        chk("t4_next_flags", 32'(flag_cnt - base), 32'd2);
        chk_out("t4n", 9'h081, 1'b0, 1'b0, 1'b0);

        // 5: 3-clk glitch on idle line
        base      = flag_cnt;
        seen_busy = 1'b0;
        ended     = 1'b0;
        rx        = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) rx = 1'b1;
            @(negedge clk);
            if (rx_busy === 1'b1) seen_busy = 1'b1;
            else if (seen_busy && !ended) ended = 1'b1;
        end
        chk("t5_busy_seen", 32'(seen_busy), 32'd1);
        chk("t5_busy_end", 32'(ended), 32'd1);
        repeat (32) @(negedge clk);
        chk("t5_no_flag", 32'(flag_cnt - base), 32'd0);

        // 6: reset during data bit 3, then 0x3C
        base = flag_cnt;
        d = 8'h3C;
        send_bit(1'b0);
        for (int unsigned i = 0; i < 3; i++) send_bit(d[i]);
        rx = d[3];
        repeat (8) @(negedge clk);
        chk("t6_busy_pre", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        chk("t6_rst_busy", 32'(rx_busy), 32'd0);
        chk("t6_rst_flag", 32'(po_flag), 32'd0);
        chk_out("t6r", 9'h000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("t6_no_flag", 32'(flag_cnt - base), 32'd0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        repeat (32) @(negedge clk);
        chk("t6_flags", 32'(flag_cnt - base), 32'd1);
        chk_out("t6", 9'h03C, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
